// File: rtl/rx_pkt_scheduler_pkg.sv
// Shared RX-path definitions: scheduler state encodings, parameter defaults
// and a small channel-count helper.
package rx_pkt_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLDOFF = 3'd3
    } sched_state_e;

    localparam int CMD_BURST_DEF = 2;
    localparam int TIMEOUT_DEF   = 1023;
    localparam int HOLDOFF_DEF   = 2;

    function automatic logic [3:0] clamp_channels(input logic [3:0] req,
                                                  input logic [3:0] lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/rx_pkt_scheduler_if.sv
// Scheduler <-> FIFO status / packet builder signals. The master modport is
// the scheduler side; the slave modport is the surrounding RX path.
interface rx_pkt_scheduler_if #(
    parameter int NUM_CHAN = 2
);
    logic [3:0]        channels;
    logic [NUM_CHAN:0] chan_ready;
    logic              have_space;
    logic              pkt_done;
    logic              clear_status;
    logic              pkt_start;
    logic [3:0]        pkt_chan;
    logic              busy;
    logic              timeout_err;
    logic [15:0]       debugbus;

    modport master (
        input  channels, chan_ready, have_space, pkt_done, clear_status,
        output pkt_start, pkt_chan, busy, timeout_err, debugbus
    );

    modport slave (
        output channels, chan_ready, have_space, pkt_done, clear_status,
        input  pkt_start, pkt_chan, busy, timeout_err, debugbus
    );
endinterface

// File: rtl/rx_rr_pick.sv
// Round-robin picker: first set request at or after 'start', wrapping at
// 'count' (start is expected to be below count).
module rx_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   start,
    input  logic [3:0]   count,
    output logic [3:0]   idx,
    output logic         found
);
    logic [15:0] req_pad;
    logic [4:0]  pos;

    // NOTE: every variable gets a default before any branch, so no path leaves it undriven (no latch).
    always_comb begin
        req_pad = 16'(req);
        pos     = '0;
        idx     = '0;
        found   = 1'b0;
        for (int off = 0; off < N; off++) begin
            pos = 5'(start) + 5'(off);
            if (pos >= {1'b0, count}) pos = pos - {1'b0, count};
            if (!found && (5'(off) < {1'b0, count}) && req_pad[pos[3:0]]) begin
                idx   = pos[3:0];
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rx_pkt_scheduler.sv
// RX packet scheduler: picks the next FIFO (command or round-robin data),
// starts the packet builder, supervises completion with a timeout, then idles.
module rx_pkt_scheduler
    import rx_pkt_scheduler_pkg::*;
#(
    parameter int NUM_CHAN  = 2,
    parameter int CMD_BURST = CMD_BURST_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int HOLDOFF   = HOLDOFF_DEF
) (
    input logic                rxclk,
    input logic                reset,
    rx_pkt_scheduler_if.master bus
);
    localparam logic [3:0] CMD_IDX   = 4'(NUM_CHAN);
    localparam logic [2:0] BURST_LIM = 3'(CMD_BURST);
    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);
    localparam logic [9:0] HOLD_LAST = 10'(HOLDOFF - 1);

    sched_state_e      state_q, state_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [3:0]        pkt_chan_q, pkt_chan_d;
    logic [3:0]        last_data_q, last_data_d;
    logic [1:0]        cmd_run_q, cmd_run_d;
    logic              timeout_err_q, timeout_err_d;

    logic [3:0]        ch_clamp, rr_start, rr_idx;
    logic [NUM_CHAN:0] mask, eligible;
    logic              data_any, cmd_win, rr_found;

    always_comb begin : sel_c
        ch_clamp = clamp_channels(bus.channels, CMD_IDX);
        mask     = '0;
        for (int i = 0; i < NUM_CHAN; i++) mask[i] = (4'(i) < ch_clamp);
        mask[NUM_CHAN] = 1'b1;
        eligible = bus.chan_ready & mask;
        data_any = |eligible[NUM_CHAN-1:0];
        cmd_win  = eligible[NUM_CHAN] && (({1'b0, cmd_run_q} < BURST_LIM) || !data_any);
        // A stale last_data beyond a shrunken channel count restarts at 0.
        rr_start = (last_data_q + 4'd1 >= ch_clamp) ? 4'd0 : last_data_q + 4'd1;
    end

    rx_rr_pick #(.N(NUM_CHAN)) u_rr_pick (
        .req   (eligible[NUM_CHAN-1:0]),
        .start (rr_start),
        .count (ch_clamp),
        .idx   (rr_idx),
        .found (rr_found)
    );

    always_ff @(posedge rxclk) begin : state_r
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pkt_chan_q    <= '0;
            last_data_q   <= 4'(NUM_CHAN - 1);
            cmd_run_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pkt_chan_q    <= pkt_chan_d;
            last_data_q   <= last_data_d;
            cmd_run_q     <= cmd_run_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin : next_c
        state_d       = state_q;
        cnt_d         = cnt_q;
        pkt_chan_d    = pkt_chan_q;
        last_data_d   = last_data_q;
        cmd_run_d     = cmd_run_q;
        timeout_err_d = bus.clear_status ? 1'b0 : timeout_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.have_space && (cmd_win || rr_found)) begin
                    state_d = ST_GRANT;
                    if (cmd_win) begin
                        pkt_chan_d = CMD_IDX;
                        if (cmd_run_q != 2'b11) cmd_run_d = cmd_run_q + 2'd1;
                    end else begin
                        pkt_chan_d  = rr_idx;
                        last_data_d = rr_idx;
                        cmd_run_d   = '0;
                    end
                end
            end
            ST_GRANT: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // Completion in the final allowed cycle beats the timeout.
                if (bus.pkt_done || cnt_q == WAIT_LAST) begin
                    if (!bus.pkt_done) timeout_err_d = 1'b1;
                    cnt_d = '0;
                    if (HOLDOFF == 0) state_d = ST_IDLE;
                    else              state_d = ST_HOLDOFF;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : out_c
        bus.pkt_start   = (state_q == ST_GRANT);
        bus.busy        = (state_q != ST_IDLE);
        bus.pkt_chan    = pkt_chan_q;
        bus.timeout_err = timeout_err_q;
        bus.debugbus    = {state_q, pkt_chan_q, cmd_run_q, timeout_err_q, 6'(eligible)};
    end
endmodule
